// File: rtl/physics_pkg.sv
// Shared types and constants for the physics update scheduler.
package physics_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    NEXT  = 2'd3
  } state_t;

  localparam logic [7:0] KEY_JUMP  = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam int GRAV_DIV_DEF = 4;
  localparam int XIN_DIV_DEF  = 4;
  localparam int YIN_DIV_DEF  = 16;

endpackage

// File: rtl/physics_frame_divider.sv
// Sweep-rate divider: counts sweep starts and fires once the count reaches LIMIT.
// With SATURATE set, the count parks at LIMIT until the gate allows it to fire.
module frame_divider #(
  parameter int LIMIT    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic gate,
  output logic fire
);

  localparam int CW = $clog2(LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] count;

  // fire looks at the count before this sweep's increment, so it can be
  // latched by the scheduler on the same edge that advances the counter.
  assign fire = gate && (count >= LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (step) begin
      if (fire) begin
        count <= '0;
      end else if (!(SATURATE && (count >= LIM))) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/physics_sched.sv
// Time-multiplexes one motion-update datapath across N_ENT entities, one sweep
// per video frame, with one frame of tick queueing and a sticky overrun flag.
module physics_sched
  import physics_pkg::*;
#(
  parameter int N_ENT    = 4,
  parameter int GRAV_DIV = GRAV_DIV_DEF,
  parameter int XIN_DIV  = XIN_DIV_DEF,
  parameter int YIN_DIV  = YIN_DIV_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [7:0]               keycode,
  input  logic [N_ENT-1:0]         ent_en,
  input  logic                     upd_ready,
  input  logic                     upd_done,
  output logic                     upd_valid,
  output logic [$clog2(N_ENT)-1:0] upd_idx,
  output logic                     grav_en,
  output logic                     xin_en,
  output logic                     yin_en,
  output logic [7:0]               key_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int IW = $clog2(N_ENT);
  localparam logic [IW-1:0] LAST = IW'(N_ENT - 1);

  state_t          state;
  logic            pending;
  logic [N_ENT-1:0] mask;
  logic            start;
  logic [IW-1:0]   idx_inc;
  logic            grav_fire;
  logic            xin_fire;
  logic            yin_fire;

  assign start   = (state == IDLE) && (frame_tick || pending);
  assign idx_inc = upd_idx + 1'b1;

  frame_divider #(.LIMIT(GRAV_DIV - 1), .SATURATE(1'b0)) u_grav (
    .clk(clk), .reset(reset), .step(start), .gate(1'b1), .fire(grav_fire)
  );

  frame_divider #(.LIMIT(XIN_DIV - 1), .SATURATE(1'b0)) u_xin (
    .clk(clk), .reset(reset), .step(start), .gate(1'b1), .fire(xin_fire)
  );

  frame_divider #(.LIMIT(YIN_DIV), .SATURATE(1'b1)) u_yin (
    .clk(clk), .reset(reset), .step(start), .gate(keycode == KEY_JUMP), .fire(yin_fire)
  );

  // NOTE: every state and output register uses <= so all of them update from
  // the same pre-edge values; a blocking assignment here would leak ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      upd_idx    <= '0;
      upd_valid  <= 1'b0;
      grav_en    <= 1'b0;
      xin_en     <= 1'b0;
      yin_en     <= 1'b0;
      key_out    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      mask       <= '0;
    end else begin
      frame_done <= 1'b0;

      if (frame_tick && (state != IDLE)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            mask      <= ent_en;
            upd_idx   <= '0;
            upd_valid <= ent_en[0];
            grav_en   <= grav_fire;
            xin_en    <= xin_fire;
            yin_en    <= yin_fire;
            key_out   <= keycode;
            // A queued tick starts this sweep; a fresh tick arriving with it re-queues.
            pending   <= pending && frame_tick;
          end
        end

        ISSUE: begin
          if (mask[upd_idx]) begin
            if (upd_ready) begin
              upd_valid <= 1'b0;
              state     <= WAIT;
            end
          end else if (upd_idx == LAST) begin
            state <= NEXT;
          end else begin
            upd_idx   <= idx_inc;
            upd_valid <= mask[idx_inc];
            key_out   <= 8'h00;
          end
        end

        WAIT: begin
          if (upd_done) state <= NEXT;
        end

        NEXT: begin
          if (upd_idx == LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            upd_idx    <= '0;
            grav_en    <= 1'b0;
            xin_en     <= 1'b0;
            yin_en     <= 1'b0;
            key_out    <= 8'h00;
          end else begin
            state     <= ISSUE;
            upd_idx   <= idx_inc;
            upd_valid <= mask[idx_inc];
            key_out   <= 8'h00;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_physics_sched.sv
// Randomized bench for physics_sched with a sweep-level reference model.
module tb_physics_sched;

  localparam int N  = 4;
  localparam int GD = 4;
  localparam int XD = 4;
  localparam int YD = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_tick;
  logic [7:0]   keycode;
  logic [N-1:0] ent_en;
  logic         upd_ready;
  logic         upd_done;
  logic         upd_valid;
  logic [1:0]   upd_idx;
  logic         grav_en;
  logic         xin_en;
  logic         yin_en;
  logic [7:0]   key_out;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  int total = 0;
  int bad   = 0;
  int sweep_k   = 0;
  int last_jump = 0;
  int yin_sweeps[$];
  int got_idx[$];
  int sweep_cycles;

  physics_sched #(.N_ENT(N), .GRAV_DIV(GD), .XIN_DIV(XD), .YIN_DIV(YD)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
    .ent_en(ent_en), .upd_ready(upd_ready), .upd_done(upd_done),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .grav_en(grav_en),
    .xin_en(xin_en), .yin_en(yin_en), .key_out(key_out), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b1; upd_ready = 1'b1; upd_done = 1'b0;
    keycode = 8'h1A; ent_en = '1;
    step(); step();
    reset = 1'b0; frame_tick = 1'b0; upd_ready = 1'b0; keycode = 8'h00; ent_en = '0;
    sweep_k = 0; last_jump = 0;
    yin_sweeps.delete();
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({upd_valid, upd_idx, grav_en, xin_en, yin_en, key_out, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL %s: outputs got valid=%0b idx=%0d en=%0b%0b%0b key=%0h busy=%0b done=%0b, required all 0",
               name, upd_valid, upd_idx, grav_en, xin_en, yin_en, key_out, busy, frame_done);
    end
  endtask

  // One full sweep. Inputs are presented before the start edge; with do_tick=0
  // the sweep is expected to start from a queued tick.
  task automatic run_sweep(input logic [N-1:0] mask, input logic [7:0] key, input bit do_tick,
                           input int stall_idx, input int stall_n, input int extra_ticks);
    bit exp_g, exp_x, exp_y, finished, stalling;
    int done_timer, stall_left, exp_idx[$];
    ent_en  = mask;
    keycode = key;
    sweep_k++;
    exp_g = (sweep_k % GD) == 0;
    exp_x = (sweep_k % XD) == 0;
    exp_y = (key == 8'h1A) && (sweep_k - last_jump > YD);
    if (exp_y) begin
      last_jump = sweep_k;
      yin_sweeps.push_back(sweep_k);
    end
    for (int i = 0; i < N; i++) if (mask[i]) exp_idx.push_back(i);
    if (do_tick) frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    got_idx.delete();
    done_timer = 0; stall_left = stall_n; stalling = 0; finished = 0;
    for (int c = 0; c < 300; c++) begin
      if (frame_done) begin
        sweep_cycles = c;
        finished = 1;
        total++;
        if ({busy, grav_en, xin_en, yin_en} !== 4'b0) begin
          bad++;
          $display("FAIL done_idle: busy/en got %0b%0b%0b%0b, required 0000", busy, grav_en, xin_en, yin_en);
        end
        break;
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL busy: got %0b in sweep %0d cycle %0d, required 1", busy, sweep_k, c);
      end
      total++;
      if ({grav_en, xin_en, yin_en} !== {exp_g, exp_x, exp_y}) begin
        bad++;
        $display("FAIL enables: sweep %0d got %0b%0b%0b, required %0b%0b%0b",
                 sweep_k, grav_en, xin_en, yin_en, exp_g, exp_x, exp_y);
      end
      total++;
      if (key_out !== ((upd_idx == 2'd0) ? key : 8'h00)) begin
        bad++; $display("FAIL key_out: idx %0d got %0h, required %0h", upd_idx, key_out,
                        (upd_idx == 2'd0) ? key : 8'h00);
      end
      if (upd_valid && !mask[upd_idx]) begin
        total++; bad++;
        $display("FAIL masked_req: got request for idx %0d, required none (mask %b)", upd_idx, mask);
      end
      upd_done = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) upd_done = 1'b1;
      end
      if (!stalling && stall_left > 0 && upd_valid && int'(upd_idx) == stall_idx) stalling = 1;
      if (stalling && stall_left > 0) begin
        total++;
        if (upd_valid !== 1'b1 || int'(upd_idx) != stall_idx) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b idx=%0d, required valid=1 idx=%0d",
                   upd_valid, upd_idx, stall_idx);
        end
        upd_ready = 1'b0;
        upd_done  = 1'b1;
        stall_left--;
      end else begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          got_idx.push_back(int'(upd_idx));
          done_timer = 2;
        end
      end
      frame_tick = (extra_ticks > 0) && (c % 2 == 1);
      if (frame_tick) extra_ticks--;
      step();
    end
    upd_ready = 1'b0; upd_done = 1'b0; frame_tick = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL sweep_timeout: sweep %0d got no frame_done in 300 cycles, required one", sweep_k);
    end
    total++;
    if (got_idx != exp_idx) begin
      bad++;
      $display("FAIL transfers: sweep %0d got %p, required %p", sweep_k, got_idx, exp_idx);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      total++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || upd_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s: got busy=%0b done=%0b valid=%0b, required 0", name, busy, frame_done, upd_valid);
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_outputs");
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b, required 0", overrun); end
    expect_quiet(3, "reset_idle");
  endtask

  task automatic test_basic();
    do_reset();
    run_sweep(4'hF, 8'h00, 1, -1, 0, 0);
    step();
    expect_quiet(5, "single_frame_done");
  endtask

  task automatic test_stall();
    do_reset();
    run_sweep(4'hF, 8'h07, 1, 1, 5, 0);
  endtask

  task automatic test_zero_mask();
    do_reset();
    run_sweep(4'h0, 8'h04, 1, -1, 0, 0);
    total++;
    if (sweep_cycles != N + 1) begin
      bad++; $display("FAIL zero_mask_len: got %0d cycles, required %0d", sweep_cycles, N + 1);
    end
  endtask

  task automatic test_mask_and_reset();
    do_reset();
    run_sweep(4'b0101, 8'h1A, 1, -1, 0, 0);
    step();
    ent_en = 4'b0101; frame_tick = 1'b1; upd_ready = 1'b0;
    step();
    frame_tick = 1'b0;
    total++;
    if (upd_valid !== 1'b1 || upd_idx !== 2'd0) begin
      bad++; $display("FAIL wait_setup: got valid=%0b idx=%0d, required 1/0", upd_valid, upd_idx);
    end
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0; reset = 1'b1;
    step();
    check_all_zero("reset_in_wait");
    reset = 1'b0; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_quiet(8, "no_done_after_reset");
    sweep_k = 0; last_jump = 0; yin_sweeps.delete();
  endtask

  task automatic test_dividers();
    do_reset();
    for (int s = 0; s < 8; s++) run_sweep(N'($urandom), 8'h00, 1, -1, 0, 0);
    total++;
    if (yin_sweeps.size() != 0) begin
      bad++; $display("FAIL no_key_jump: got %0d jump sweeps, required 0", yin_sweeps.size());
    end
  endtask

  task automatic test_jump();
    int req[$];
    req = '{17, 34};
    do_reset();
    for (int s = 0; s < 40; s++) run_sweep(N'($urandom), 8'h1A, 1, -1, 0, 0);
    total++;
    if (yin_sweeps != req) begin
      bad++; $display("FAIL jump_sweeps: got %p, required %p", yin_sweeps, req);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run_sweep(4'hF, 8'h00, 1, -1, 0, 3);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %0b, required 1", overrun); end
    run_sweep(4'b1010, 8'h00, 0, -1, 0, 0);
    step();
    expect_quiet(6, "one_queued_only");
    run_sweep(4'hF, 8'h00, 1, -1, 0, 0);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %0b, required 1", overrun); end
    do_reset();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %0b, required 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys [4];
    keys = '{8'h1A, 8'h04, 8'h07, 8'h00};
    do_reset();
    for (int s = 0; s < 24; s++) begin
      keys[3] = 8'($urandom);
      run_sweep(N'($urandom), keys[$urandom_range(3, 0)], 1, $urandom_range(N - 1, 0),
                $urandom_range(3, 0), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_mask();
    test_mask_and_reset();
    test_dividers();
    test_jump();
    test_overrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/physics_sched.md
PHYSICS_SCHED -- requirements
Module: physics_sched

Interface
REQ-001 Parameter N_ENT, default 4, number of entities sharing one motion-update datapath.
REQ-002 Parameter GRAV_DIV, default 4, frames between gravity enables.
REQ-003 Parameter XIN_DIV, default 4, frames between horizontal-input enables.
REQ-004 Parameter YIN_DIV, default 16, minimum frames between jump grants.
REQ-005 Clk  in  1  system clock; all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 keycode  in  8  current keyboard code.
REQ-009 ent_en  in  N_ENT  per-entity enable mask.
REQ-010 upd_ready  in  1  datapath accepts a request.
REQ-011 upd_done  in  1  one-cycle pulse when the accepted update completes.
REQ-012 upd_valid  out  1  request to datapath.
REQ-013 upd_idx  out  $clog2(N_ENT)  entity index of request.
REQ-014 grav_en, xin_en, yin_en  out  1 each  per-frame step enables.
REQ-015 key_out  out  8  keycode for the current entity; 8'h00 for idx != 0.
REQ-016 busy  out  1  high outside IDLE.
REQ-017 frame_done  out  1  one-cycle pulse at end of sweep.
REQ-018 overrun  out  1  sticky; set when a frame could not start on time.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, NEXT; IDLE->ISSUE on frame_tick or pending.
REQ-020 At sweep start, latch ent_en, keycode and the three enables; hold all constant for the sweep.
REQ-021 Gravity counter increments per sweep start; grav_en=1 and counter clears when counter >= GRAV_DIV-1.
REQ-022 X counter behaves identically with XIN_DIV; xin_en independent of keycode.
REQ-023 Jump counter increments per sweep start, saturating at YIN_DIV; yin_en=1 only if counter >= YIN_DIV and latched keycode == 8'h1A, then counter clears.
REQ-024 ISSUE: skip entities with latched enable 0 (one cycle each, no request); otherwise upd_valid=1 with upd_idx.
REQ-025 Request transfers when upd_valid && upd_ready in the same cycle; upd_valid and upd_idx stay stable until then; ISSUE->WAIT.
REQ-026 WAIT->NEXT on upd_done; upd_done outside WAIT is ignored.
REQ-027 NEXT: if idx == N_ENT-1 pulse frame_done and go IDLE, else idx+1 and go ISSUE.
REQ-028 All-zero mask: sweep still runs, no upd_valid, frame_done after N_ENT skip cycles plus NEXT.
REQ-029 frame_tick while busy: set pending (depth 1); second tick while pending sets overrun and is dropped.
REQ-030 Pending cleared when the next sweep starts; overrun cleared only by Reset.
REQ-031 frame_tick on the same cycle as frame_done: treated as pending, sweep restarts next cycle.
REQ-032 grav_en/xin_en/yin_en outputs are 0 in IDLE.

Reset
REQ-033 On Reset: state IDLE, idx 0, all counters 0, pending 0, overrun 0.
REQ-034 On Reset all outputs 0 (upd_valid, upd_idx, enables, key_out, busy, frame_done).
REQ-035 Reset mid-sweep abandons the outstanding request; no frame_done is issued.

Structure
REQ-036 Package physics_pkg holds the state enum, KEY_JUMP=8'h1A, KEY_LEFT=8'h04, KEY_RIGHT=8'h07 and divisor defaults.
REQ-037 One sub-module frame_divider (counter + compare, optional saturate-and-gate) instantiated for gravity, X and jump.

Verification
REQ-038 Reset, one frame_tick, ready=1, done 2 cycles after accept, mask 4'hF -> upd_idx 0,1,2,3 in order, one frame_done.
REQ-039 upd_ready low 5 cycles on idx 1 -> upd_valid, upd_idx=1 held stable all 5 cycles, single transfer.
REQ-040 8 sweeps, no keys -> grav_en and xin_en high on sweeps 4 and 8 only; yin_en never high.
REQ-041 keycode 8'h1A held 40 sweeps -> yin_en on sweeps 17 and 34 only; key_out 8'h1A only while upd_idx=0.
REQ-042 Three frame_ticks during one sweep -> one queued sweep, overrun=1 and stays 1 until Reset.
REQ-043 Mask 4'b0101 -> requests only idx 0 and 2; Reset asserted in WAIT -> all outputs 0 next cycle.
